accum_result_collector: RTL

ACCUM_RESULT_COLLECTOR -- requirements
Module: accum_result_collector

---
 rtl/types.sv | 16 +
 rtl/accum_cfg_decoder.sv | 28 ++
 rtl/accum_result_collector.sv | 112 +++++++++++
 3 files changed

// File: rtl/types.sv
// Shared types for the accumulator result path.
// Data word, group-size config and collector state encoding.
package types;

    localparam int DATA_W    = 32;
    localparam int ACC_CFG_W = 4;

    typedef logic [DATA_W-1:0]    data_type;
    typedef logic [ACC_CFG_W-1:0] acc_cfg_t;

    typedef enum logic {
        ST_IDLE,
        ST_DRAIN
    } coll_state_e;

endpackage

// File: rtl/accum_cfg_decoder.sv
// Group-size to accumulator select-vector decode.
// Pure combinational so other controllers can reuse it.
import types::*;

module accum_cfg_decoder #(
    parameter int IN_SIZE = 16
) (
    input  acc_cfg_t               cfg_i,
    output logic [2:IN_SIZE-1]     adder_chain_set_o,
    output logic [1:IN_SIZE-1]     out_data_mux_o
);

    int k;

    always_comb begin
        k                 = int'(cfg_i) + 1;
        adder_chain_set_o = '0;
        out_data_mux_o    = '0;
        for (int i = 2; i < IN_SIZE; i++) begin
            adder_chain_set_o[i] = ((i % k) >= 2);
        end
        // lane closing a group drives its sum out; k=1 has no chaining
        for (int i = 1; i < IN_SIZE; i++) begin
            out_data_mux_o[i] = (k > 1) && ((i % k) == (k - 1));
        end
    end

endmodule

// File: rtl/accum_result_collector.sv
// Captures one accumulator result array and streams the group sums
// out one beat per handshake, in ascending lane order.
import types::*;

module accum_result_collector #(
    parameter int IN_SIZE = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_load_i,
    input  acc_cfg_t           group_cfg_i,
    output logic [2:IN_SIZE-1] adder_chain_set_o,
    output logic [1:IN_SIZE-1] out_data_mux_o,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  data_type           data_i [0:IN_SIZE-1],
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output data_type           out_data_o,
    output logic [3:0]         out_idx_o,
    output logic               out_last_o
);

    localparam logic [4:0] MAX_LANE = 5'(IN_SIZE - 1);

    coll_state_e state_q, state_d;
    acc_cfg_t    cfg_q, cfg_d;
    data_type    buf_q [0:IN_SIZE-1];
    data_type    buf_d [0:IN_SIZE-1];
    data_type    out_data_q, out_data_d;
    logic [3:0]  idx_q, idx_d;
    logic        last_q, last_d;

    acc_cfg_t    cfg_eff;
    logic [4:0]  step;
    logic [4:0]  first_nxt;
    logic [4:0]  nxt;
    logic [4:0]  nxt_nxt;

    accum_cfg_decoder #(
        .IN_SIZE(IN_SIZE)
    ) u_dec (
        .cfg_i            (cfg_q),
        .adder_chain_set_o(adder_chain_set_o),
        .out_data_mux_o   (out_data_mux_o)
    );

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        buf_d      = buf_q;
        out_data_d = out_data_q;
        idx_d      = idx_q;
        last_d     = last_q;

        cfg_eff   = cfg_load_i ? group_cfg_i : cfg_q;
        first_nxt = {1'b0, cfg_eff} + {1'b0, cfg_eff} + 5'd1;
        step      = {1'b0, cfg_q} + 5'd1;
        nxt       = {1'b0, idx_q} + step;
        nxt_nxt   = nxt + step;

        unique case (state_q)
            ST_IDLE: begin
                cfg_d = cfg_eff;
                if (in_valid_i) begin
                    // first result lane is k-1, i.e. the cfg value itself
                    buf_d      = data_i;
                    state_d    = ST_DRAIN;
                    idx_d      = cfg_eff;
                    out_data_d = data_i[cfg_eff];
                    last_d     = (first_nxt > MAX_LANE);
                end
            end
            ST_DRAIN: begin
                if (out_ready_i) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d      = nxt[3:0];
                        out_data_d = buf_q[nxt[3:0]];
                        last_d     = (nxt_nxt > MAX_LANE);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            buf_q      <= '{default: '0};
            out_data_q <= '0;
            idx_q      <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            buf_q      <= buf_d;
            out_data_q <= out_data_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_DRAIN);
    assign out_data_o  = out_data_q;
    assign out_idx_o   = idx_q;
    assign out_last_o  = last_q;

endmodule
